load_unit: RTL and testbench
============================

Name: load_unit

Overview:
Multi-cycle load execution unit for the execution-cycle datapath.
- Accepts one load request per transaction: base register value, 16-bit immediate offset, destination register, access size, signedness.
- Computes the effective address as base + sign-extended immediate and issues one word-aligned read to data memory over a variable-latency valid handshake.
- Extracts the addressed byte, halfword or word and sign- or zero-extends it.
- Drives a one-cycle write-back to the register file.

Parameters:
- DATA_W, 32: datapath and memory word width. Legal values are 32 or 64.
- IMM_W, 16: immediate width; sign-extended to DATA_W.
- REG_AW, 5: register index width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low (0 = reset).
- req_valid  input  1  load request present.
- req_ready  output  1  unit can accept a request; high only in IDLE.
- req_base  input  DATA_W  base register value.
- req_imm  input  IMM_W  offset immediate.
- req_rd  input  REG_AW  destination register.
- req_size  input  2  access size: 00 byte, 01 half, 10 word(32), 11 dword (DATA_W=64 only).
- req_unsigned  input  1  1 = zero-extend, 0 = sign-extend.
- mem_req  output  1  one-cycle read strobe.
- mem_addr  output  DATA_W  word-aligned address; low log2(DATA_W/8) bits are 0.
- mem_rdata  input  DATA_W  read data, valid when mem_rvalid=1.
- mem_rvalid  input  1  read data valid.
- wb_en  output  1  register-file write enable pulse.
- wb_reg  output  REG_AW  write-back register index.
- wb_data  output  DATA_W  extended load result.
- err  output  1  one-cycle misalignment/illegal-size pulse.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - req_ready=1. mem_req, wb_en, err, busy = 0.
  - mem_addr, wb_reg, wb_data = 0. All internal registers are cleared.
- States: IDLE, REQ, WAIT, WB, ERR.
- IDLE: on req_valid & req_ready at an edge:
  - Register ea = req_base + sext(req_imm), truncated to DATA_W.
  - Register size, unsigned, rd.
  - Go to REQ if access is legal, else go to ERR.
- Legality:
  - byte: always legal.
  - half: requires ea[0]=0.
  - word: requires ea[1:0]=0.
  - dword: requires DATA_W=64 and ea[2:0]=0. size=11 with DATA_W=32 is illegal.
- ERR: err=1 for exactly one cycle, no mem_req, no wb_en; then IDLE.
- REQ: mem_req=1 for exactly one cycle with mem_addr = ea with the low lane bits cleared; then WAIT.
- WAIT:
  - Hold mem_addr.
  - On mem_rvalid=1, capture the lane selected by ea's low bits (little-endian), extend per size/unsigned into wb_data, then go to WB.
  - No timeout; WAIT persists indefinitely.
- mem_rvalid handling:
  - mem_rvalid in the same cycle as mem_req is not sampled.
  - mem_rvalid in IDLE, REQ, WB or ERR is ignored.
- WB:
  - wb_en=1 for one cycle with wb_reg=rd, unless rd==0, in which case wb_en stays 0.
  - wb_data is driven regardless of rd.
  - Next state is IDLE.
- Latency: with mem_rvalid one cycle after mem_req, wb_en is high in the 3rd cycle after the accepting edge. Each extra memory wait cycle adds one cycle.
- wb_data and wb_reg hold their values after WB until the next WB.
- req_ready is low from the accepting edge until return to IDLE. No request queuing; req_valid while busy is not consumed.
- Extension:
  - Byte: bits [7:0] replicated per sign.
  - Half: bits [15:0].
  - Word with DATA_W=64: bits [31:0] extended.
  - Dword: passthrough.
- Reset mid-operation: the transaction is abandoned and no wb_en is produced. A mem_rvalid arriving after reset release is ignored.

Test Plan:
1. Memory word at 0x64 = 0x8899AABB; LB base=0x60, imm=0x0006, rd=3, signed -> mem_addr=0x64, wb_en=1, wb_reg=3, wb_data=0xFFFFFF99, 3 cycles after accept.
2. Same load with req_unsigned=1 -> wb_data=0x00000099. LH base=0x68, imm=0xFFFE (-2), signed -> ea=0x66, wb_data=0xFFFF8899.
3. LW base=0x64, imm=0, rd=7, memory holds mem_rvalid low for 4 extra cycles -> mem_req single pulse, busy high throughout, req_ready low, wb_data=0x8899AABB, wb_en 7 cycles after accept.
4. LW at ea=0x66 and LH at ea=0x65 -> err pulses one cycle each, no mem_req, no wb_en, req_ready high the following cycle. size=11 with DATA_W=32 -> err.
5. LW to rd=0 -> full memory transaction, wb_data=0x8899AABB, wb_en stays 0.
6. Assert reset=0 during WAIT, release, then pulse mem_rvalid -> all outputs 0, IDLE, req_ready=1, no wb_en. A following LB completes correctly.

Source files
------------

// File: rtl/load_unit.sv
// load_unit: multi-cycle load execution unit (EA calc, aligned memory read, lane extract, extend, write-back)
//
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready, req_base, req_imm, req_rd, req_size, req_unsigned : load request
//   mem_req, mem_addr, mem_rdata, mem_rvalid : word-aligned read with variable latency
//   wb_en, wb_reg, wb_data : one-cycle register-file write-back
//   err  : one-cycle pulse for a misaligned or illegal-size request
//   busy : high whenever a transaction is in flight
module load_unit #(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 16,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DATA_W-1:0] req_base,
   input  logic [IMM_W-1:0]  req_imm,
   input  logic [REG_AW-1:0] req_rd,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   output logic              mem_req,
   output logic [DATA_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rvalid,
   output logic              wb_en,
   output logic [REG_AW-1:0] wb_reg,
   output logic [DATA_W-1:0] wb_data,
   output logic              err,
   output logic              busy
);
   localparam int LB = $clog2(DATA_W / 8);
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_WB, S_ERR} state_t;
   state_t              r_state, w_next;
   logic [DATA_W-1:0]   r_ea, r_wb_data;
   logic [1:0]          r_size;
   logic                r_uns;
   logic [REG_AW-1:0]   r_rd, r_wb_reg;
   logic [DATA_W-1:0]   w_ea, w_lane, w_mask, w_top, w_ext;
   logic [6:0]          w_nbits;
   logic                w_legal, w_accept, w_neg;
   assign w_ea     = req_base + {{(DATA_W - IMM_W){req_imm[IMM_W-1]}}, req_imm};
   assign w_accept = req_valid && (r_state == S_IDLE);
   always_comb
      w_legal = (req_size == 2'd0) ? 1'b1 :
                (req_size == 2'd1) ? !w_ea[0] :
                (req_size == 2'd2) ? (w_ea[1:0] == 2'b00) :
                                     ((DATA_W == 64) && (w_ea[2:0] == 3'b000));
   // Little-endian lane select, then extend using a width mask; the mask's top
   // set bit picks the sign bit without a variable-width index.
   assign w_lane  = mem_rdata >> {r_ea[LB-1:0], 3'b000};
   assign w_nbits = (r_size == 2'd0) ? 7'd8 : (r_size == 2'd1) ? 7'd16 :
                    (r_size == 2'd2) ? 7'd32 : 7'(DATA_W);
   assign w_mask  = {DATA_W{1'b1}} >> (7'(DATA_W) - w_nbits);
   assign w_top   = w_mask & ~(w_mask >> 1);
   assign w_neg   = !r_uns && |(w_lane & w_top);
   assign w_ext   = (w_lane & w_mask) | ({DATA_W{w_neg}} & ~w_mask);
   always_ff @(posedge clk or negedge reset)
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = !req_valid ? S_IDLE : w_legal ? S_REQ : S_ERR;
         S_REQ:   w_next = S_WAIT;
         S_WAIT:  w_next = mem_rvalid ? S_WB : S_WAIT;
         default: w_next = S_IDLE;
      endcase
   end
   always_comb begin
      req_ready = (r_state == S_IDLE);
      busy      = (r_state != S_IDLE);
      mem_req   = (r_state == S_REQ);
      err       = (r_state == S_ERR);
      wb_en     = (r_state == S_WB) && (r_rd != '0);
      mem_addr  = {r_ea[DATA_W-1:LB], {LB{1'b0}}};
      wb_reg    = r_wb_reg;
      wb_data   = r_wb_data;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_ea      <= '0;
         r_size    <= '0;
         r_uns     <= 1'b0;
         r_rd      <= '0;
         r_wb_data <= '0;
         r_wb_reg  <= '0;
      end else begin
         if (w_accept) begin
            r_ea   <= w_ea;
            r_size <= req_size;
            r_uns  <= req_unsigned;
            r_rd   <= req_rd;
         end
         // wb_data/wb_reg are loaded on capture so they are valid during WB and hold afterwards.
         if (r_state == S_WAIT && mem_rvalid) begin
            r_wb_data <= w_ext;
            r_wb_reg  <= r_rd;
         end
      end
endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: table-driven and randomized self-checking bench for load_unit (DATA_W=32)
module tb_load_unit;
   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_unsigned;
   logic [31:0] req_base;
   logic [15:0] req_imm;
   logic [4:0]  req_rd;
   logic [1:0]  req_size;
   logic        mem_req, mem_rvalid;
   logic [31:0] mem_addr, mem_rdata;
   logic        wb_en, err, busy;
   logic [4:0]  wb_reg;
   logic [31:0] wb_data;
   always #5 clk = ~clk;
   load_unit #(.DATA_W(32), .IMM_W(16), .REG_AW(5)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_base(req_base), .req_imm(req_imm),
      .req_rd(req_rd), .req_size(req_size), .req_unsigned(req_unsigned),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
      .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .err(err), .busy(busy)
   );
   typedef struct {
      logic [31:0] base;
      logic [15:0] imm;
      logic [4:0]  rd;
      logic [1:0]  size;
      logic        uns;
      int          extra;
      bit          early;
      bit          exp_err;
      logic [31:0] exp_addr;
      logic [31:0] exp_data;
   } vec_t;
   int          checks = 0, failures = 0;
   logic [31:0] wordmem [64];
   logic [31:0] last_data;
   logic [4:0]  last_reg;
   vec_t        tbl [11];
   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask
   // Reference: read the aligned word, shift to the byte offset, keep n bytes, extend arithmetically.
   function automatic logic [31:0] model_load(input logic [31:0] ea, input logic [1:0] size, input logic uns);
      longint unsigned w, v, lim, one;
      longint          s;
      int              nb;
      one = 1;
      nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      w   = longint'(wordmem[ea[7:2]]);
      lim = one << (8 * nb);
      v   = (w >> (8 * ea[1:0])) % lim;
      s   = longint'(v);
      if (!uns && v >= (lim >> 1)) s = s - longint'(lim);
      return s[31:0];
   endfunction
   function automatic bit model_legal(input logic [31:0] ea, input logic [1:0] size);
      case (size)
         2'd0:    return 1'b1;
         2'd1:    return (ea % 2) == 0;
         2'd2:    return (ea % 4) == 0;
         default: return 1'b0;
      endcase
   endfunction
   task automatic run_txn(input vec_t v, input string tag);
      int          nreq = 0, nwb = 0, nerr = 0, reqc = -1, wbc = -1, errc = -1, idlec = -1;
      bit          bad = 0;
      logic [31:0] addr = 0;
      @(negedge clk);
      chk({tag, ".ready_before"}, req_ready, 1);
      req_valid = 1; req_base = v.base; req_imm = v.imm; req_rd = v.rd;
      req_size = v.size; req_unsigned = v.uns;
      @(posedge clk);
      for (int cyc = 1; cyc <= 40 && idlec < 0; cyc++) begin
         @(negedge clk);
         if (cyc == 1) req_valid = 0;
         if (req_ready) idlec = cyc;
         else if (!busy) bad = 1;
         if (mem_req) begin nreq++; addr = mem_addr; if (reqc < 0) reqc = cyc; end
         if (wb_en) begin nwb++; wbc = cyc; end
         if (err) begin nerr++; errc = cyc; end
         mem_rvalid = 0;
         mem_rdata  = $urandom;
         if (reqc >= 0 && cyc == reqc + 1 + v.extra) begin
            mem_rvalid = 1;
            mem_rdata  = wordmem[mem_addr[7:2]];
         end else if (v.early && reqc >= 0 && (cyc == reqc || cyc == reqc + 2 + v.extra)) mem_rvalid = 1;
      end
      mem_rvalid = 0;
      chk({tag, ".completes"}, idlec > 0, 1);
      chk({tag, ".busy_while_active"}, bad, 0);
      if (v.exp_err) begin
         chk({tag, ".err_count"}, nerr, 1);
         chk({tag, ".err_cycle"}, errc, 1);
         chk({tag, ".no_mem_req"}, nreq, 0);
         chk({tag, ".no_wb"}, nwb, 0);
         chk({tag, ".ready_after_err"}, idlec, 2);
         chk({tag, ".wb_data_held"}, wb_data, last_data);
         chk({tag, ".wb_reg_held"}, wb_reg, last_reg);
      end else begin
         chk({tag, ".no_err"}, nerr, 0);
         chk({tag, ".mem_req_count"}, nreq, 1);
         chk({tag, ".mem_addr"}, addr, v.exp_addr);
         chk({tag, ".wb_count"}, nwb, (v.rd != 0) ? 1 : 0);
         if (v.rd != 0) chk({tag, ".wb_cycle"}, wbc, 3 + v.extra);
         chk({tag, ".idle_cycle"}, idlec, 4 + v.extra);
         chk({tag, ".wb_data"}, wb_data, v.exp_data);
         chk({tag, ".wb_reg"}, wb_reg, v.rd);
         last_data = v.exp_data;
         last_reg  = v.rd;
      end
   endtask
   initial begin
      reset = 0; req_valid = 0; req_base = 0; req_imm = 0; req_rd = 0; req_size = 0;
      req_unsigned = 0; mem_rvalid = 0; mem_rdata = 0;
      last_data = 0; last_reg = 0;
      for (int i = 0; i < 64; i++) wordmem[i] = $urandom;
      wordmem[25] = 32'h8899AABB;
      tbl[0]  = '{32'h60, 16'h0006, 5'd3,  2'd0, 1'b0, 0, 1'b0, 1'b0, 32'h64, 32'hFFFFFF99};
      tbl[1]  = '{32'h60, 16'h0006, 5'd3,  2'd0, 1'b1, 0, 1'b1, 1'b0, 32'h64, 32'h00000099};
      tbl[2]  = '{32'h68, 16'hFFFE, 5'd4,  2'd1, 1'b0, 0, 1'b0, 1'b0, 32'h64, 32'hFFFF8899};
      tbl[3]  = '{32'h64, 16'h0000, 5'd7,  2'd2, 1'b0, 4, 1'b1, 1'b0, 32'h64, 32'h8899AABB};
      tbl[4]  = '{32'h60, 16'h0006, 5'd5,  2'd2, 1'b0, 0, 1'b0, 1'b1, 32'h0,  32'h0};
      tbl[5]  = '{32'h60, 16'h0005, 5'd5,  2'd1, 1'b0, 0, 1'b0, 1'b1, 32'h0,  32'h0};
      tbl[6]  = '{32'h60, 16'h0004, 5'd6,  2'd3, 1'b0, 0, 1'b0, 1'b1, 32'h0,  32'h0};
      tbl[7]  = '{32'h64, 16'h0000, 5'd0,  2'd2, 1'b0, 1, 1'b1, 1'b0, 32'h64, 32'h8899AABB};
      tbl[8]  = '{32'h64, 16'h0002, 5'd31, 2'd1, 1'b1, 2, 1'b0, 1'b0, 32'h64, 32'h00008899};
      tbl[9]  = '{32'h64, 16'h0000, 5'd1,  2'd0, 1'b0, 0, 1'b0, 1'b0, 32'h64, 32'hFFFFFFBB};
      tbl[10] = '{32'h68, 16'hFFFF, 5'd2,  2'd0, 1'b1, 3, 1'b1, 1'b0, 32'h64, 32'h00000088};
      repeat (2) @(negedge clk);
      chk("rst.ready", req_ready, 1);
      chk("rst.busy", busy, 0);
      chk("rst.mem_req", mem_req, 0);
      chk("rst.wb_en", wb_en, 0);
      chk("rst.err", err, 0);
      chk("rst.mem_addr", mem_addr, 0);
      chk("rst.wb_reg", wb_reg, 0);
      chk("rst.wb_data", wb_data, 0);
      reset = 1;
      for (int i = 0; i < 11; i++) run_txn(tbl[i], $sformatf("vec%0d", i));
      // Reset asserted while waiting for memory: transaction must be abandoned.
      @(negedge clk);
      req_valid = 1; req_base = 32'h64; req_imm = 0; req_rd = 5'd9; req_size = 2'd2; req_unsigned = 0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 0;
      @(negedge clk);
      chk("midrst.busy_in_wait", busy, 1);
      reset = 0;
      #1;
      chk("midrst.ready", req_ready, 1);
      chk("midrst.busy", busy, 0);
      chk("midrst.mem_req", mem_req, 0);
      chk("midrst.wb_en", wb_en, 0);
      chk("midrst.err", err, 0);
      chk("midrst.mem_addr", mem_addr, 0);
      chk("midrst.wb_reg", wb_reg, 0);
      chk("midrst.wb_data", wb_data, 0);
      @(negedge clk);
      reset = 1; mem_rvalid = 1; mem_rdata = 32'h8899AABB;
      @(negedge clk);
      mem_rvalid = 0;
      for (int i = 0; i < 3; i++) begin
         chk("midrst.late_rvalid_wb_en", wb_en, 0);
         chk("midrst.late_rvalid_ready", req_ready, 1);
         @(negedge clk);
      end
      chk("midrst.wb_data_after", wb_data, 0);
      last_data = 0; last_reg = 0;
      run_txn(tbl[0], "post_reset_lb");
      // Randomized transactions against the reference model.
      for (int n = 0; n < 200; n++) begin
         vec_t        v;
         logic [31:0] ea;
         v.base  = $urandom;
         v.imm   = 16'($urandom);
         v.rd    = 5'($urandom);
         v.size  = 2'($urandom);
         v.uns   = 1'($urandom);
         v.extra = $urandom_range(0, 3);
         v.early = 1'($urandom);
         ea      = v.base + {{16{v.imm[15]}}, v.imm};
         v.exp_err  = !model_legal(ea, v.size);
         v.exp_addr = ea & 32'hFFFFFFFC;
         v.exp_data = model_load(ea, v.size, v.uns);
         run_txn(v, $sformatf("rnd%0d", n));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
